// File: rtl/cache_ctrl_pkg.sv
// Shared defaults, FSM state encoding and helpers for the direct-mapped
// write-through cache controller.
package cache_ctrl_pkg;

  localparam int DEF_ADDR_SIZE  = 8;
  localparam int DEF_TAG_SIZE   = 3;
  localparam int DEF_CACHE_SIZE = 32;
  localparam int DEF_DATA_SIZE  = 8;
  localparam int CNT_SIZE       = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    MEM_RD  = 3'd2,
    MEM_WR  = 3'd3,
    RESPOND = 3'd4
  } ctrlState;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_SIZE-1:0] satInc(input logic [CNT_SIZE-1:0] value);
    return (value == {CNT_SIZE{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data storage for the cache: combinational read by index,
// one synchronous write port, and a one-cycle clear of every valid bit.
module cache_line_store
  import cache_ctrl_pkg::*;
#(
  parameter int TAG_SIZE   = DEF_TAG_SIZE,
  parameter int CACHE_SIZE = DEF_CACHE_SIZE,
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  localparam int INDEX_SIZE = $clog2(CACHE_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_SIZE-1:0] rdIdx,
  output logic                  rdValid,
  output logic [TAG_SIZE-1:0]   rdTag,
  output logic [DATA_SIZE-1:0]  rdData,
  input  logic                  wrEn,
  input  logic [INDEX_SIZE-1:0] wrIdx,
  input  logic [TAG_SIZE-1:0]   wrTag,
  input  logic [DATA_SIZE-1:0]  wrData
);

  logic [CACHE_SIZE-1:0] validBits;
  logic [TAG_SIZE-1:0]   tagMem  [CACHE_SIZE];
  logic [DATA_SIZE-1:0]  dataMem [CACHE_SIZE];

  for (genvar gi = 0; gi < CACHE_SIZE; gi++) begin : gValid
    always_ff @(posedge clk) begin
      if (reset) begin
        validBits[gi] <= 1'b0;
      end else if (wrEn && (wrIdx == INDEX_SIZE'(gi))) begin
        validBits[gi] <= 1'b1;
      end
    end
  end

  // Tag/data are never cleared; a write coinciding with reset is dropped so
  // an aborted fill leaves no trace.
  always_ff @(posedge clk) begin
    if (wrEn && !reset) begin
      tagMem[wrIdx]  <= wrTag;
      dataMem[wrIdx] <= wrData;
    end
  end

  assign rdValid = validBits[rdIdx];
  assign rdTag   = tagMem[rdIdx];
  assign rdData  = dataMem[rdIdx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-through, write-allocate cache controller: CPU request
// port, single-word req/ack memory port, saturating hit/miss statistics.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int TAG_SIZE   = DEF_TAG_SIZE,
  parameter int CACHE_SIZE = DEF_CACHE_SIZE,
  parameter int DATA_SIZE  = DEF_DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic [DATA_SIZE-1:0] cpu_wdata,
  output logic                 cpu_ready,
  output logic [DATA_SIZE-1:0] cpu_rdata,
  output logic                 cpu_hit,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic [CNT_SIZE-1:0]  hit_count,
  output logic [CNT_SIZE-1:0]  miss_count
);

  localparam int INDEX_SIZE = ADDR_SIZE - TAG_SIZE;

  ctrlState               state;
  logic                   reqWe;
  logic [ADDR_SIZE-1:0]   reqAddr;
  logic [DATA_SIZE-1:0]   reqWdata;
  logic                   lookupHit;

  logic [INDEX_SIZE-1:0]  reqIdx;
  logic [TAG_SIZE-1:0]    reqTag;
  logic                   lineValid;
  logic [TAG_SIZE-1:0]    lineTag;
  logic [DATA_SIZE-1:0]   lineData;
  logic                   isHit;
  logic                   memDone;
  logic [DATA_SIZE-1:0]   storeData;

  assign reqIdx    = reqAddr[INDEX_SIZE-1:0];
  assign reqTag    = reqAddr[ADDR_SIZE-1 -: TAG_SIZE];
  assign isHit     = lineValid && (lineTag == reqTag);
  assign memDone   = mem_ack && ((state == MEM_RD) || (state == MEM_WR));
  assign storeData = (state == MEM_RD) ? mem_rdata : reqWdata;

  // Every completed memory access (fill or write-allocate) installs the line.
  cache_line_store #(
    .TAG_SIZE   (TAG_SIZE),
    .CACHE_SIZE (CACHE_SIZE),
    .DATA_SIZE  (DATA_SIZE)
  ) lineStore (
    .clk     (clk),
    .reset   (reset),
    .rdIdx   (reqIdx),
    .rdValid (lineValid),
    .rdTag   (lineTag),
    .rdData  (lineData),
    .wrEn    (memDone),
    .wrIdx   (reqIdx),
    .wrTag   (reqTag),
    .wrData  (storeData)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      reqWe      <= 1'b0;
      reqAddr    <= '0;
      reqWdata   <= '0;
      lookupHit  <= 1'b0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      cpu_hit    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ready <= 1'b0;
          cpu_hit   <= 1'b0;
          if (cpu_req) begin
            reqWe    <= cpu_we;
            reqAddr  <= cpu_addr;
            reqWdata <= cpu_wdata;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          lookupHit <= isHit;
          if (isHit) begin
            hit_count <= satInc(hit_count);
          end else begin
            miss_count <= satInc(miss_count);
          end
          if (reqWe) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= reqAddr;
            mem_wdata <= reqWdata;
            state     <= MEM_WR;
          end else if (isHit) begin
            cpu_rdata <= lineData;
            cpu_hit   <= 1'b1;
            cpu_ready <= 1'b1;
            state     <= RESPOND;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= reqAddr;
            state    <= MEM_RD;
          end
        end
        MEM_RD: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            cpu_rdata <= mem_rdata;
            cpu_hit   <= 1'b0;
            cpu_ready <= 1'b1;
            state     <= RESPOND;
          end
        end
        MEM_WR: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            cpu_hit   <= lookupHit;
            cpu_ready <= 1'b1;
            state     <= RESPOND;
          end
        end
        RESPOND: begin
          cpu_ready <= 1'b0;
          cpu_hit   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed vector table, hand-written
// corner sequences, and randomized traffic against a resident-address model.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [7:0]  cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic        cpu_hit;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cpu_hit    (cpu_hit),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int passCount  = 0;
  int totalCount = 0;

  // Backing memory plus the model: which full address each index holds.
  logic [7:0] memArr [256];
  int         lineAddr [int];
  int         expHitCnt;
  int         expMissCnt;
  logic [7:0] lastRdata;

  // Observations from the most recent transaction.
  logic [7:0] txRdata;
  logic       txHit;
  logic       txSawMem;
  logic       txMemWe;
  logic [7:0] txMemAddr;
  logic [7:0] txMemWdata;
  logic       txReqAtReady;
  int         txReadyCyc;
  int         txMemCyc;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         ackDelay;
    logic       expHit;
    logic [7:0] expRdata;
    int         expReady;
    int         expHits;
    int         expMisses;
  } vecRec;

  vecRec vecs [8];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual === expected) passCount++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic modelReset();
    lineAddr.delete();
    expHitCnt  = 0;
    expMissCnt = 0;
    lastRdata  = 8'h00;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset   = 1'b1;
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  // Issues one CPU request and plays the memory side; cycle 1 is the cycle
  // right after the edge that sampled cpu_req.
  task automatic doTxn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                       input int ackDelay);
    int  cyc;
    logic done;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    cpu_req    = 1'b0;
    cyc        = 1;
    done       = 1'b0;
    txSawMem   = 1'b0;
    txReadyCyc = -1;
    txMemCyc   = -1;
    for (int k = 0; k < 60 && !done; k++) begin
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
      if (cpu_ready) begin
        txReadyCyc   = cyc;
        txRdata      = cpu_rdata;
        txHit        = cpu_hit;
        txReqAtReady = mem_req;
        done         = 1'b1;
      end else if (mem_req) begin
        if (!txSawMem) begin
          txSawMem   = 1'b1;
          txMemCyc   = cyc;
          txMemWe    = mem_we;
          txMemAddr  = mem_addr;
          txMemWdata = mem_wdata;
        end
        if (cyc - txMemCyc == ackDelay) begin
          mem_ack = 1'b1;
          if (we) memArr[addr] = wdata;
          else    mem_rdata = memArr[addr];
        end
      end
      if (!done) begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    mem_ack = 1'b0;
    if (!done) $display("FAIL txn_timeout: addr 0x%0h got no cpu_ready, expected one", addr);
    $display("txn we=%0b addr=0x%02h wdata=0x%02h ack=%0d -> ready@%0d rdata=0x%02h hit=%0b hc=%0d mc=%0d",
             we, addr, wdata, ackDelay, txReadyCyc, txRdata, txHit, hit_count, miss_count);
  endtask

  // One transaction checked against the resident-address model.
  task automatic runModelTxn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                             input int ackDelay);
    int         idx;
    logic       expHit;
    logic [7:0] expRd;
    idx    = int'(addr) % 32;
    expHit = 1'b0;
    if (lineAddr.exists(idx)) expHit = (lineAddr[idx] == int'(addr));
    expRd  = we ? lastRdata : memArr[addr];
    doTxn(we, addr, wdata, ackDelay);
    if (expHit) expHitCnt = (expHitCnt < 65535) ? expHitCnt + 1 : 65535;
    else        expMissCnt = (expMissCnt < 65535) ? expMissCnt + 1 : 65535;
    check("model_hit", 32'(txHit), 32'(expHit));
    check("model_rdata", 32'(txRdata), 32'(expRd));
    check("model_ready_cycle", 32'(txReadyCyc), (!we && expHit) ? 32'd2 : 32'(3 + ackDelay));
    check("model_mem_access", 32'(txSawMem), 32'(we || !expHit));
    if (txSawMem) begin
      check("model_mem_addr", 32'(txMemAddr), 32'(addr));
      check("model_mem_we", 32'(txMemWe), 32'(we));
      if (we) check("model_mem_wdata", 32'(txMemWdata), 32'(wdata));
    end
    check("model_req_low_at_ready", 32'(txReqAtReady), 32'd0);
    check("model_hit_count", 32'(hit_count), 32'(expHitCnt));
    check("model_miss_count", 32'(miss_count), 32'(expMissCnt));
    lineAddr[idx] = int'(addr);
    if (!we) lastRdata = expRd;
  endtask

  initial begin
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 8'h00;
    cpu_wdata = 8'h00;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    for (int i = 0; i < 256; i++) memArr[i] = 8'($urandom);
    memArr[8'h25] = 8'hA5;
    memArr[8'hC5] = 8'h77;
    modelReset();

    vecs[0] = '{1'b0, 8'h25, 8'h00, 2, 1'b0, 8'hA5, 5, 0, 1};
    vecs[1] = '{1'b0, 8'h25, 8'h00, 0, 1'b1, 8'hA5, 2, 1, 1};
    vecs[2] = '{1'b1, 8'h45, 8'h3C, 1, 1'b0, 8'hA5, 4, 1, 2};
    vecs[3] = '{1'b0, 8'h45, 8'h00, 0, 1'b1, 8'h3C, 2, 2, 2};
    vecs[4] = '{1'b0, 8'h25, 8'h00, 0, 1'b0, 8'hA5, 3, 2, 3};
    vecs[5] = '{1'b1, 8'h25, 8'h5A, 0, 1'b1, 8'hA5, 3, 3, 3};
    vecs[6] = '{1'b0, 8'h25, 8'h00, 3, 1'b1, 8'h5A, 2, 4, 3};
    vecs[7] = '{1'b0, 8'hC5, 8'h00, 0, 1'b0, 8'h77, 3, 4, 4};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_cpu_hit", 32'(cpu_hit), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_miss_count", 32'(miss_count), 32'd0);

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      doTxn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ackDelay);
      check($sformatf("vec%0d_hit", i), 32'(txHit), 32'(vecs[i].expHit));
      check($sformatf("vec%0d_rdata", i), 32'(txRdata), 32'(vecs[i].expRdata));
      check($sformatf("vec%0d_ready_cycle", i), 32'(txReadyCyc), 32'(vecs[i].expReady));
      check($sformatf("vec%0d_hit_count", i), 32'(hit_count), 32'(vecs[i].expHits));
      check($sformatf("vec%0d_miss_count", i), 32'(miss_count), 32'(vecs[i].expMisses));
      check($sformatf("vec%0d_mem_access", i), 32'(txSawMem), 32'(vecs[i].we || !vecs[i].expHit));
      if (txSawMem) begin
        check($sformatf("vec%0d_mem_addr", i), 32'(txMemAddr), 32'(vecs[i].addr));
        check($sformatf("vec%0d_mem_we", i), 32'(txMemWe), 32'(vecs[i].we));
        if (vecs[i].we) check($sformatf("vec%0d_mem_wdata", i), 32'(txMemWdata), 32'(vecs[i].wdata));
      end
      check($sformatf("vec%0d_req_low_at_ready", i), 32'(txReqAtReady), 32'd0);
    end

    // Reset while waiting in MEM_RD, with a coincident ack that must be lost.
    doReset();
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 8'h25;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_mem_req_before", 32'(mem_req), 32'd1);
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 8'hEE;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_mem_req_after", 32'(mem_req), 32'd0);
    check("abort_miss_count", 32'(miss_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_ready", 32'(cpu_ready), 32'd0);
      check("abort_stray_ack_no_req", 32'(mem_req), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    modelReset();
    $display("txn reset-abort read 0x25 done");
    runModelTxn(1'b0, 8'h25, 8'h00, 1);

    // Extra cpu_req during MEM_WR, ack in the cycle mem_req rises.
    doReset();
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 8'h10;
    cpu_wdata = 8'h99;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("memwr_req", 32'(mem_req), 32'd1);
    check("memwr_we", 32'(mem_we), 32'd1);
    check("memwr_addr", 32'(mem_addr), 32'h10);
    check("memwr_wdata", 32'(mem_wdata), 32'h99);
    mem_ack  = 1'b1;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 8'h33;
    memArr[8'h10] = 8'h99;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    cpu_req = 1'b0;
    check("memwr_ready", 32'(cpu_ready), 32'd1);
    check("memwr_hit", 32'(cpu_hit), 32'd0);
    check("memwr_req_dropped", 32'(mem_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("memwr_extra_req_ignored_ready", 32'(cpu_ready), 32'd0);
      check("memwr_extra_req_ignored_mem", 32'(mem_req), 32'd0);
    end
    expMissCnt = 1;
    lineAddr[16] = 32'h10;
    check("memwr_miss_count", 32'(miss_count), 32'(expMissCnt));
    $display("txn write 0x10 with ack on req rise, extra req ignored");

    // Saturation of the hit counter.
    @(negedge clk);
    force dut.hit_count = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.hit_count;
    @(posedge clk);
    @(negedge clk);
    check("sat_preload", 32'(hit_count), 32'hFFFE);
    expHitCnt = 16'hFFFE;
    runModelTxn(1'b0, 8'h10, 8'h00, 0);
    runModelTxn(1'b0, 8'h10, 8'h00, 0);
    check("sat_hold", 32'(hit_count), 32'hFFFF);

    // Randomized traffic on a few indices so hits, misses and replacements mix.
    doReset();
    for (int n = 0; n < 250; n++) begin
      logic [7:0] a;
      a = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 3))};
      runModelTxn(($urandom_range(0, 3) == 0), a, 8'($urandom), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped, write-through cache controller. It is the initiator/owner side of the valid-bit array.
- Accepts CPU read/write requests and looks up valid, tag and data storage. Sets valid bits on fill or write, and clears them on reset.
- Issues single-word requests to main memory over a req/ack handshake.
- Sits between the CPU-side request port and the memory model.

Parameters:
- ADDR_SIZE, 8, CPU/memory word address width.
- TAG_SIZE, 3, upper address bits stored as tag. Index = address[ADDR_SIZE-TAG_SIZE-1:0].
- CACHE_SIZE, 32, number of lines. Must equal 2**(ADDR_SIZE-TAG_SIZE).
- DATA_SIZE, 8, data word width. One word per line.

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU request strobe, sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read; latched with cpu_req
- cpu_addr  in  ADDR_SIZE  request address; latched with cpu_req
- cpu_wdata  in  DATA_SIZE  write data; latched with cpu_req
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_SIZE  read data, valid while cpu_ready=1
- cpu_hit  out  1  lookup result of completing request, valid while cpu_ready=1
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable, stable while mem_req=1
- mem_addr  out  ADDR_SIZE  memory address, stable while mem_req=1
- mem_wdata  out  DATA_SIZE  memory write data, stable while mem_req=1
- mem_ack  in  1  memory completion; read data valid same cycle
- mem_rdata  in  DATA_SIZE  memory read data
- hit_count  out  16  saturating hit counter
- miss_count  out  16  saturating miss counter

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- On a reset edge:
  - all CACHE_SIZE valid bits are cleared in that single cycle;
  - the FSM goes to IDLE;
  - cpu_ready, cpu_hit, mem_req, mem_we are 0;
  - cpu_rdata, mem_addr, mem_wdata are 0;
  - both counters are 0.
  - Tag and data arrays are not cleared; contents are don't-care while invalid.
- FSM states: IDLE, LOOKUP, MEM_RD, MEM_WR, RESPOND.
- IDLE: when cpu_req=1, latch cpu_we, cpu_addr and cpu_wdata, then go to LOOKUP. Otherwise stay in IDLE.
- LOOKUP: compare valid[idx] && tag[idx]==addr[ADDR_SIZE-1:ADDR_SIZE-TAG_SIZE].
  - Read hit: cpu_rdata<=data[idx], cpu_hit<=1, hit_count++, go to RESPOND.
  - Read miss: miss_count++, go to MEM_RD.
  - Write, hit or miss: counters count the hit/miss as for reads, go to MEM_WR.
- MEM_RD: mem_req=1, mem_we=0, mem_addr=latched addr.
  - On mem_ack: data[idx]<=mem_rdata, tag[idx]<=addr tag, valid[idx]<=1, cpu_rdata<=mem_rdata, cpu_hit<=0, go to RESPOND.
  - mem_req deasserts on the cycle after the ack.
- MEM_WR: mem_req=1, mem_we=1, mem_wdata=latched wdata.
  - On mem_ack: data[idx]<=wdata, tag[idx]<=addr tag, valid[idx]<=1 (write-allocate), cpu_hit<=lookup result, go to RESPOND.
- RESPOND: cpu_ready=1 for exactly one cycle, then go to IDLE.
  - cpu_rdata is held until the next RESPOND.
  - cpu_hit returns to 0 in IDLE.
- Latency from the cpu_req sampling edge:
  - read hit: cpu_ready high in the 2nd cycle after;
  - miss or write: cpu_ready high 1 cycle after the mem_ack cycle.
- Boundary conditions:
  - cpu_req outside IDLE is ignored, with no queuing. cpu_req held high in RESPOND is accepted in the following IDLE cycle.
  - mem_ack outside MEM_RD/MEM_WR is ignored.
  - mem_ack in the same cycle mem_req first rises is legal and completes.
  - No timeout: MEM states wait indefinitely.
  - Reset mid-transaction aborts: mem_req=0 after that edge, no array update, no cpu_ready.
  - Counters saturate at 16'hFFFF and do not wrap.
  - Index wrap: address bits above the index only affect the tag. Same-index, different-tag accesses replace the line.

Decomposition:
- define.v holds ADDR_SIZE, TAG_SIZE, CACHE_SIZE, DATA_SIZE defaults and the FSM state encodings (3-bit localparams).
- One natural sub-module, cache_line_store, holds the valid, tag and data arrays:
  - single-cycle clear of the valid bits on reset;
  - combinational read by index;
  - one synchronous write port (idx, tag, data, set-valid).
- cache_ctrl holds the FSM, latches, counters and the memory handshake.

Test Plan:
- Reset, then read 0x25 with mem_ack 2 cycles after mem_req and mem_rdata=0xA5 -> mem_addr=0x25, mem_we=0; cpu_ready one cycle, cpu_rdata=0xA5, cpu_hit=0; miss_count=1.
- Repeat read 0x25 -> no mem_req; cpu_ready 2 cycles after req; cpu_rdata=0xA5, cpu_hit=1; hit_count=1.
- Write 0x45 (same idx 5, tag 2) data 0x3C, then read 0x25 -> write: mem_we=1, mem_wdata=0x3C. Read 0x25 then misses and goes to memory; read 0x45 hits with 0x3C.
- Reset asserted while in MEM_RD awaiting ack -> mem_req=0 next edge, no cpu_ready. A following read of the same address misses (valid cleared).
- cpu_req pulsed while in MEM_WR, mem_ack asserted in the same cycle mem_req rises -> extra req ignored; completion within 2 cycles.
- Force hit_count to 16'hFFFE via 2 further hits -> reads 16'hFFFF and stays there.
